noc_rx_arbiter: RTL
===================

Name: noc_rx_arbiter

Overview:
- Shares one consumer port between N_RX noc_serial_receiver instances.
- Each cycle it round-robin selects one receiver holding a complete packet (valid high), registers that receiver's packet and padding onto a valid/ready output, and pulses the receiver's flush input for one cycle so it can accept a new packet.
- Sits between the per-port serial receivers and the node-local consumer (core or DMA).

Parameters:
- N_RX, 4, number of attached receivers (>=2).
- PACKET_BITS, 16, packet width per receiver.
- PADDING_BITS, 8, padding width per receiver (>=1).
- CNT_WIDTH, 16, width of the delivered-packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  grant enable; 0 = no new grants, an output already held stays valid.
- rx_valid  in  N_RX  per-receiver valid.
- rx_packet  in  N_RX*PACKET_BITS  packets; receiver i at [i*PACKET_BITS +: PACKET_BITS].
- rx_padding  in  N_RX*PADDING_BITS  padding, same packing.
- rx_flush  out  N_RX  one-hot flush pulse to receivers.
- out_valid  out  1  output holds a packet.
- out_ready  in  1  consumer accepts.
- out_packet  out  PACKET_BITS  granted packet.
- out_padding  out  PADDING_BITS  granted padding.
- out_src  out  $clog2(N_RX)  index of the source receiver.
- pkt_count  out  CNT_WIDTH  number of packets accepted by the consumer.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: out_valid=0, out_packet=0, out_padding=0, out_src=0, rx_flush=0, pkt_count=0.
  - Internal: rr_ptr=0, state=IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Eligibility:
  - elig = rx_valid & ~rx_flush.
  - A receiver flushed in the current cycle still shows valid=1 this cycle. It must not be re-granted.
- Round-robin pick:
  - Choose the first set bit of elig scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_RX.
  - On every grant, rr_ptr <= (granted+1) mod N_RX. Wrap from N_RX-1 goes to 0.
- can_load = en & (elig!=0) & (state==IDLE | out_ready).
- FSM states: IDLE (out_valid=0) and HOLD (out_valid=1).
- IDLE:
  - If can_load: register out_packet, out_padding and out_src from the granted receiver; rx_flush <= onehot(granted); go to HOLD.
  - Otherwise stay in IDLE with rx_flush <= 0.
- HOLD, out_ready=0:
  - out_* held stable (no change while out_valid=1 & !out_ready).
  - rx_flush <= 0.
- HOLD, out_ready=1 (handshake):
  - pkt_count <= pkt_count+1, wrapping at 2^CNT_WIDTH.
  - If can_load: load the next grant exactly as in IDLE and stay in HOLD (back-to-back, 1 packet/cycle).
  - Otherwise go to IDLE, out_valid <= 0, rx_flush <= 0.
- Latency:
  - Receiver valid at cycle t while IDLE: out_valid=1 and rx_flush[i]=1 at t+1.
  - Receiver valid drops at t+2.
- rx_flush:
  - Is high for exactly one cycle per grant.
  - Is never asserted for a receiver whose valid is 0.
  - At most one bit is set.
- en=0:
  - No new grants and no flush pulses.
  - A held output still completes its handshake and moves to IDLE.
- All rx_valid low while HOLD: the handshake still completes and the block returns to IDLE.
- Simultaneous valids: served strictly in round-robin order. No receiver waits more than N_RX-1 grants.
- Reset mid-operation:
  - The pending packet is discarded and not counted.
  - rx_flush is deasserted in the same cycle reset is sampled.
  - Receivers share rst and clear independently.

Test Plan:
- Single packet: rx_valid=0100, rx_packet[2]=16'hBEEF, out_ready=1 -> at t+1 out_valid=1, out_packet=BEEF, out_src=2, rx_flush=0100 for 1 cycle; pkt_count=1; rr_ptr=3.
- Fairness: all 4 receivers valid and re-asserting valid 1 cycle after their flush, out_ready=1 -> out_src sequence 0,1,2,3,0,1; out_valid continuously 1; no receiver flushed twice in a row.
- Backpressure: grant receiver 1 with packet 16'h1234, out_ready=0 for 5 cycles -> out_packet stays 1234; rx_flush=0010 only in the first cycle; no further grant; out_ready=1 -> pkt_count+1.
- Wrap and ptr: rr_ptr=3, rx_valid=1001 -> grant 3 then 0; rr_ptr goes 0 then 1; CNT_WIDTH=4 with 16 handshakes -> pkt_count wraps to 0.
- Enable gate: en=0 with rx_valid=1111 -> no rx_flush, out_valid stays 0; en=1 -> grant at rr_ptr next cycle.
- Reset in HOLD: out_valid=1 and rst=1 for 1 cycle -> next cycle out_valid=0, rx_flush=0, pkt_count=0, rr_ptr=0, state IDLE.

Source files
------------

// File: rtl/noc_rx_arbiter.sv
// noc_rx_arbiter: round-robin arbiter moving complete receiver packets onto one registered valid/ready port
module noc_rx_arbiter #(
  parameter int N_RX = 4,
  parameter int PACKET_BITS = 16,
  parameter int PADDING_BITS = 8,
  parameter int CNT_WIDTH = 16,
  localparam int SW = $clog2(N_RX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_RX-1:0]              rx_valid,
  input  logic [N_RX*PACKET_BITS-1:0]  rx_packet,
  input  logic [N_RX*PADDING_BITS-1:0] rx_padding,
  output logic [N_RX-1:0]              rx_flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PACKET_BITS-1:0]       out_packet,
  output logic [PADDING_BITS-1:0]      out_padding,
  output logic [SW-1:0]                out_src,
  output logic [CNT_WIDTH-1:0]         pkt_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [N_RX-1:0] flush_q, flush_d, elig;
  logic [SW-1:0] rr_q, rr_d, src_q, src_d, grant, idx;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic [PADDING_BITS-1:0] pad_q, pad_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic found, can_load, hs;
  logic [PACKET_BITS-1:0] pkts [N_RX];
  logic [PADDING_BITS-1:0] pads [N_RX];
  for (genvar g = 0; g < N_RX; g++) begin : g_unpack
    assign pkts[g] = rx_packet[g*PACKET_BITS +: PACKET_BITS];
    assign pads[g] = rx_padding[g*PADDING_BITS +: PADDING_BITS];
  end
  // a receiver flushed this cycle still shows valid, so it is masked out
  assign elig = rx_valid & ~flush_q;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N_RX; k++) begin
      idx = SW'((int'(rr_q) + k) % N_RX);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  assign hs = (state_q == HOLD) && out_ready;
  assign can_load = en && found && (state_q == IDLE || out_ready);
  always_comb begin
    state_d = state_q;
    flush_d = '0;
    rr_d = rr_q;
    src_d = src_q;
    pkt_d = pkt_q;
    pad_d = pad_q;
    cnt_d = cnt_q + CNT_WIDTH'(hs);
    if (can_load) begin
      state_d = HOLD;
      flush_d = N_RX'(1) << grant;
      rr_d = (grant == SW'(N_RX - 1)) ? '0 : grant + SW'(1);
      src_d = grant;
      pkt_d = pkts[grant];
      pad_d = pads[grant];
    end else if (hs) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flush_q <= '0;
      rr_q <= '0;
      src_q <= '0;
      pkt_q <= '0;
      pad_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      rr_q <= rr_d;
      src_q <= src_d;
      pkt_q <= pkt_d;
      pad_q <= pad_d;
      cnt_q <= cnt_d;
    end
  end
  assign rx_flush = flush_q;
  assign out_valid = (state_q == HOLD);
  assign out_packet = pkt_q;
  assign out_padding = pad_q;
  assign out_src = src_q;
  assign pkt_count = cnt_q;
endmodule
